// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter: shift-and-add-3, one operand bit per clock.
// Drives the 7-segment digit decoders directly, 4 bits per digit, ones digit in [3:0].
module bin_to_bcd_seq #(
  parameter int BIN_W      = 8,
  parameter int BCD_DIGITS = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [BIN_W-1:0]        i_bin,
  output logic [4*BCD_DIGITS-1:0] o_bcd,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    dbg_state
);

  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  localparam longint unsigned MAX_BIN = (longint'(1) << BIN_W) - 1;

  generate
    if (BIN_W < 1 || BIN_W > 16 || pow10(BCD_DIGITS) <= MAX_BIN) begin : g_param_check
      $error("bin_to_bcd_seq: BIN_W must be 1..16 and 10**BCD_DIGITS must exceed 2**BIN_W-1");
    end
  endgenerate

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [BIN_W-1:0] bin_sr;
  logic [BCD_W-1:0] bcd_sr;
  logic [CNT_W-1:0] cnt;
  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] bcd_shift;

  // Handshake: a request is accepted on any edge where i_start=1 and o_busy=0;
  // o_busy stays high until the edge that raises o_done, and i_start is ignored meanwhile.
  assign dbg_state = state;

  // Each digit is corrected on its own; a corrected digit never carries into its neighbour.
  always_comb begin
    bcd_adj = bcd_sr;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (bcd_sr[4*d +: 4] >= 4'd5) begin
        bcd_adj[4*d +: 4] = bcd_sr[4*d +: 4] + 4'd3;
      end
    end
  end

  assign bcd_shift = (bcd_adj << 1) | {{(BCD_W-1){1'b0}}, bin_sr[BIN_W-1]};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state  <= S_IDLE;
      bin_sr <= '0;
      bcd_sr <= '0;
      cnt    <= '0;
      o_bcd  <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            bin_sr <= i_bin;
            bcd_sr <= '0;
            cnt    <= '0;
            o_busy <= 1'b1;
            state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          bcd_sr <= bcd_shift;
          bin_sr <= bin_sr << 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST_ITER) begin
            o_bcd  <= bcd_shift;
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed and randomized bench for bin_to_bcd_seq using a divide-by-10 reference
// model and a FIFO scoreboard popped on every o_done pulse.
module tb_bin_to_bcd_seq;

  localparam int BIN_W      = 8;
  localparam int BCD_DIGITS = 3;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  logic             i_clk;
  logic             i_rst_n;
  logic             i_start;
  logic [BIN_W-1:0] i_bin;
  logic [BCD_W-1:0] o_bcd;
  logic             o_busy;
  logic             o_done;
  logic             dbg_state;

  int  tests  = 0;
  int  failed = 0;
  int  cyc    = 0;
  bit  mon_en = 0;
  logic [BCD_W-1:0] exp_q[$];
  logic [BCD_W-1:0] mon_exp;

  bin_to_bcd_seq #(.BIN_W(BIN_W), .BCD_DIGITS(BCD_DIGITS)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (i_start),
    .i_bin    (i_bin),
    .o_bcd    (o_bcd),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [BCD_W-1:0] ref_bcd(input int v);
    logic [BCD_W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge i_clk) begin
    if (mon_en) begin
      if (o_busy && o_done) chk("busy_done_overlap", {30'd0, o_busy, o_done}, 32'd0);
      if (o_done) begin
        if (exp_q.size() == 0) begin
          chk("done_without_request", {31'd0, o_done}, 32'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("scoreboard_result", {20'd0, o_bcd}, {20'd0, mon_exp});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge while idle; checks the exact busy/done schedule.
  task automatic timed_conv(input int v, input string tag);
    logic [BCD_W-1:0] e;
    e = ref_bcd(v);
    i_bin   = BIN_W'(v);
    i_start = 1'b1;
    exp_q.push_back(e);
    @(negedge i_clk);
    i_start = 1'b0;
    chk({tag, "_busy_at_k"}, {31'd0, o_busy}, 32'd1);
    for (int i = 1; i < BIN_W; i++) begin
      @(negedge i_clk);
      chk({tag, "_busy_window"}, {30'd0, o_busy, o_done}, 32'd2);
    end
    @(negedge i_clk);
    chk({tag, "_done_at_k8"}, {30'd0, o_busy, o_done}, 32'd1);
    chk({tag, "_bcd"}, {20'd0, o_bcd}, {20'd0, e});
    @(negedge i_clk);
    chk({tag, "_done_one_cycle"}, {31'd0, o_done}, 32'd0);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && o_busy; i++) @(negedge i_clk);
    if (o_busy) chk("busy_timeout", {31'd0, o_busy}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int d1, d2, k0, got, nbusy, ndone, x;

    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_bin   = '0;
    repeat (3) @(negedge i_clk);
    chk("reset_bcd",   {20'd0, o_bcd}, 32'd0);
    chk("reset_busy",  {31'd0, o_busy}, 32'd0);
    chk("reset_done",  {31'd0, o_done}, 32'd0);
    chk("reset_state", {31'd0, dbg_state}, 32'd0);
    i_rst_n = 1'b1;
    mon_en  = 1'b1;

    // Idle with no requests.
    nbusy = 0;
    ndone = 0;
    repeat (20) begin
      @(negedge i_clk);
      nbusy += int'(o_busy);
      ndone += int'(o_done);
    end
    chk("idle_busy_count", nbusy, 0);
    chk("idle_done_count", ndone, 0);
    chk("idle_bcd", {20'd0, o_bcd}, 32'd0);

    timed_conv(255, "c255");
    timed_conv(0,   "c0");
    timed_conv(99,  "c99");
    timed_conv(100, "c100");
    timed_conv(9,   "c9");

    // Start held high: second request accepted the edge after the first completes.
    d1 = -1;
    d2 = -1;
    i_bin   = 8'd128;
    i_start = 1'b1;
    exp_q.push_back(ref_bcd(128));
    @(negedge i_clk);
    i_bin = 8'd7;
    exp_q.push_back(ref_bcd(7));
    for (int i = 0; i < 40 && d2 < 0; i++) begin
      @(negedge i_clk);
      if (o_done) begin
        if (d1 < 0) d1 = cyc;
        else begin
          d2 = cyc;
          i_start = 1'b0;
        end
      end
    end
    i_start = 1'b0;
    chk("held_done_gap", d2 - d1, 9);
    chk("held_last_bcd", {20'd0, o_bcd}, {20'd0, ref_bcd(7)});
    wait_idle(20);

    // A start pulse during SHIFT must be ignored.
    @(negedge i_clk);
    i_bin   = 8'd200;
    i_start = 1'b1;
    exp_q.push_back(ref_bcd(200));
    @(negedge i_clk);
    i_start = 1'b0;
    k0 = cyc;
    repeat (2) @(negedge i_clk);
    i_bin   = 8'd55;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    chk("ignore_busy_k3", {31'd0, o_busy}, 32'd1);
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      @(negedge i_clk);
      got = int'(o_done);
    end
    chk("ignore_latency", cyc - k0, 8);
    chk("ignore_bcd", {20'd0, o_bcd}, {20'd0, ref_bcd(200)});
    nbusy = 0;
    repeat (12) begin
      @(negedge i_clk);
      nbusy += int'(o_busy);
    end
    chk("ignore_no_restart", nbusy, 0);

    // Exhaustive sweep followed by random operands, random gaps, scrambled i_bin after capture.
    for (int v = 0; v < 256 + 60; v++) begin
      if (v < 256) x = v;
      else x = int'($urandom_range(0, 255));
      i_bin   = BIN_W'(x);
      i_start = 1'b1;
      exp_q.push_back(ref_bcd(x));
      @(negedge i_clk);
      i_start = 1'b0;
      i_bin   = BIN_W'($urandom);
      wait_idle(20);
      repeat ($urandom_range(0, 2)) @(negedge i_clk);
    end
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge i_clk);
    chk("sweep_queue_drained", exp_q.size(), 0);

    // Reset during a conversion of 77 at edge k+4.
    timed_conv(99, "pre_abort");
    i_bin   = 8'd77;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    chk("abort_bcd",   {20'd0, o_bcd}, 32'd0);
    chk("abort_busy",  {31'd0, o_busy}, 32'd0);
    chk("abort_done",  {31'd0, o_done}, 32'd0);
    chk("abort_state", {31'd0, dbg_state}, 32'd0);
    ndone = 0;
    repeat (12) begin
      @(negedge i_clk);
      ndone += int'(o_done);
    end
    chk("abort_no_done", ndone, 0);
    timed_conv(77, "after_abort");

    repeat (2) @(negedge i_clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
